mem_line_arbiter: RTL and testbench
===================================

Name: mem_line_arbiter

Overview:
- Shares the single cacheline-granular memory port between the instruction cache (read-only) and the data cache (read/write).
- Sits between the two cache miss interfaces and the burst cacheline adapter.
- Serialises line requests, one outstanding at a time.
- Default policy is fixed priority (D over I), with an anti-starvation counter that guarantees fetch forward progress.

Parameters:
- ADDR_W, 32, line address width; low 5 bits are always zero on issue.
- LINE_W, 256, cacheline data width.
- STARVE_MAX, 8, number of consecutive lost I-side arbitrations before I is forced to win.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- i_addr  in  ADDR_W  I-cache miss line address
- i_read  in  1  I-cache line read request, level, held until i_resp
- i_rdata  out  LINE_W  line returned to I-cache
- i_resp  out  1  one-cycle I-side completion pulse
- d_addr  in  ADDR_W  D-cache line address
- d_read  in  1  D-cache line read request, level
- d_write  in  1  D-cache writeback request, level; mutually exclusive with d_read
- d_wdata  in  LINE_W  writeback line
- d_rdata  out  LINE_W  line returned to D-cache
- d_resp  out  1  one-cycle D-side completion pulse
- mem_addr  out  ADDR_W  registered line address to adapter
- mem_read  out  1  registered read strobe, level until mem_resp
- mem_write  out  1  registered write strobe, level until mem_resp
- mem_wdata  out  LINE_W  registered writeback data
- mem_rdata  in  LINE_W  line from adapter, valid with mem_resp
- mem_resp  in  1  adapter completion, one cycle
- busy  out  1  high in any state other than IDLE

Behaviour:
- Clock and reset: single clock clk. rst is asynchronous active-high.
- Reset values: state IDLE; mem_addr 0; mem_read 0; mem_write 0; mem_wdata 0; busy 0; starve_cnt 0; last_winner I.
- i_resp and d_resp are 0 whenever state is IDLE.
- States are IDLE, SERVE_I and SERVE_D.
- IDLE arbitration, evaluated in cycle N on the request inputs:
  - Neither side requesting: stay in IDLE.
  - Only one side requesting: that side wins.
  - Both requesting: D wins, unless starve_cnt == STARVE_MAX, in which case I wins.
- Grant, registered at the edge ending cycle N:
  - State moves to SERVE_x.
  - mem_addr is loaded with {x_addr[ADDR_W-1:5], 5'b0}.
  - The matching strobe (mem_read or mem_write) is set; mem_wdata is loaded from d_wdata only on a write grant.
  - Request-to-strobe latency is 1 cycle.
- SERVE_x:
  - mem_* outputs are held stable until mem_resp; requester inputs are not resampled.
  - In the cycle mem_resp = 1: x_resp = 1 and x_rdata = mem_rdata, combinational pass-through, 0-cycle latency.
  - At the edge ending that cycle: strobes clear and state returns to IDLE.
- Minimum turnaround is one IDLE cycle between transactions. Back-to-back grants are therefore spaced request, strobe, ..., resp, IDLE, strobe.
- A request still asserted in the IDLE cycle after its resp is treated as a new request. Requesters must drop the level on the cycle after resp if they are done.
- Unselected rdata output is driven to 0. i_rdata and d_rdata are 0 outside their resp cycle.
- starve_cnt, saturating at STARVE_MAX:
  - Increments in IDLE when both sides request and D wins.
  - Clears on any I grant.
  - Holds otherwise.
- d_read and d_write both high is illegal. The arbiter treats it as a write; the bench flags it with an assertion.
- mem_resp while in IDLE is ignored; the bench flags it with an assertion.
- Reset asserted mid-transaction: immediate return to IDLE with strobes low. No resp is delivered, and the in-flight transaction is lost.
- Requests dropped mid-SERVE are illegal. The arbiter completes the transaction regardless and still pulses resp.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined:
  - The arbitration policy becomes round-robin on conflict: the side that is not last_winner wins.
  - last_winner updates on every grant.
  - The starvation counter and STARVE_MAX are unused; starve_cnt is held at 0.
- Undefined: fixed D-priority with the starvation counter, as described above.
- Single-requester behaviour and all timing are identical in both builds.

Test Plan:
- I-only read (i_read=1, i_addr=0x0000_1234, adapter resp 5 cycles later):
  - mem_read=1 with mem_addr=0x0000_1220 one cycle after request.
  - i_resp=1 with i_rdata=mem_rdata in the mem_resp cycle.
  - busy falls the next cycle.
- D writeback (d_write=1, d_addr=0x8000_0040, d_wdata=pattern A5..):
  - mem_write=1 with mem_wdata=pattern and mem_addr=0x8000_0040.
  - d_resp pulses with mem_resp; i_resp stays 0.
- Simultaneous i_read and d_read, both held continuously:
  - D served 8 times in a row, then I granted on the 9th conflict.
  - starve_cnt returns to 0 after the I grant.
  - With MEM_ARB_ROUND_ROBIN_EN defined, grants strictly alternate D, I, D, I.
- Back-to-back: D re-requests in the IDLE cycle after d_resp → next mem_read asserts 2 cycles after d_resp (one IDLE cycle, then strobe); address updated to the new d_addr.
- Reset mid-SERVE_D (rst pulsed 2 cycles into a transaction) → mem_read and mem_write drop asynchronously, no d_resp, state IDLE, a later i_read is served normally.
- Late mem_resp stability: adapter delays resp 50 cycles while d_addr and i_addr toggle → mem_addr and mem_wdata stay unchanged for all 50 cycles.

Source files
------------

// File: rtl/mem_line_arbiter.sv
// mem_line_arbiter
//
// Purpose
//   Shares one cacheline-granular memory port between the instruction cache
//   (read-only) and the data cache (read/write). Line requests are serialised
//   with one transaction outstanding at a time. On a conflict the default
//   policy is fixed priority, D over I. A saturating starvation counter forces
//   an I win after STARVE_MAX consecutive lost I-side arbitrations.
//
// Build option
//   MEM_ARB_ROUND_ROBIN_EN : when defined, conflicts are resolved round-robin.
//                            The side that did not win the last grant wins.
//                            The starvation counter is held at 0. Single-
//                            requester behaviour and all timing are unchanged.
//
// Handshake (both requester sides and the memory side)
//   Each requester raises its request level (i_read, d_read or d_write) and
//   holds it until its one-cycle x_resp pulse. The arbiter does not resample
//   request inputs while a transaction is in flight. A level still high in the
//   IDLE cycle after resp counts as a new request. On the memory side,
//   mem_read or mem_write is a registered level. It rises one cycle after the
//   winning request and stays up with mem_addr/mem_wdata stable until the
//   one-cycle mem_resp. mem_rdata is passed straight through to the winner in
//   that same cycle. At least one IDLE cycle separates two transactions.
//
// Ports
//   clk, rst           clock, asynchronous active-high reset
//   i_addr, i_read     I-cache miss line address / read request level
//   i_rdata, i_resp    line to I-cache / one-cycle completion pulse
//   d_addr             D-cache line address
//   d_read, d_write    D-cache read / writeback request levels
//   d_wdata            writeback line
//   d_rdata, d_resp    line to D-cache / one-cycle completion pulse
//   mem_addr           registered line address, low 5 bits zero
//   mem_read/mem_write registered strobes, level until mem_resp
//   mem_wdata          registered writeback line
//   mem_rdata/mem_resp line from adapter / one-cycle completion
//   busy               high whenever the FSM is not IDLE
//   dbg_state          current FSM state (0 IDLE, 1 SERVE_I, 2 SERVE_D)
//   dbg_starve_cnt     current starvation counter
//   dbg_last_winner    side of the most recent grant (0 I, 1 D)

module mem_line_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int LINE_W     = 256,
   parameter int STARVE_MAX = 8,
   localparam int CNT_W     = $clog2(STARVE_MAX + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic              i_read,
   output logic [LINE_W-1:0] i_rdata,
   output logic              i_resp,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [LINE_W-1:0] d_wdata,
   output logic [LINE_W-1:0] d_rdata,
   output logic              d_resp,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_read,
   output logic              mem_write,
   output logic [LINE_W-1:0] mem_wdata,
   input  logic [LINE_W-1:0] mem_rdata,
   input  logic              mem_resp,
   output logic              busy,
   output logic [1:0]        dbg_state,
   output logic [CNT_W-1:0]  dbg_starve_cnt,
   output logic              dbg_last_winner
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SERVE_I = 2'd1,
      SERVE_D = 2'd2
   } state_t;

   localparam logic             WIN_I      = 1'b0;
   localparam logic             WIN_D      = 1'b1;
   localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

   state_t            state_q;
   state_t            state_d;
   logic [CNT_W-1:0]  starve_cnt;
   logic              last_winner;

   logic              d_req;
   logic              conflict;
   logic              grant_i;
   logic              grant_d;
   logic              resp_now;

   // Line offset bits are dropped on issue; they are intentionally unused.
   logic              unused_offset_bits;
   assign unused_offset_bits = ^{i_addr[4:0], d_addr[4:0]};

   // d_read and d_write together is illegal. It is folded into a write below
   // because d_write alone selects the write path.
   assign d_req    = d_read | d_write;
   assign conflict = (state_q == IDLE) && i_read && d_req;

   // ------------------------------------------------------------------
   // Arbitration (only meaningful in IDLE)
   // ------------------------------------------------------------------
   always_comb begin
      grant_i = 1'b0;
      grant_d = 1'b0;
      if (state_q == IDLE) begin
         if (i_read && d_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            if (last_winner == WIN_D) grant_i = 1'b1;
            else                      grant_d = 1'b1;
`else
            if (starve_cnt == STARVE_LIM) grant_i = 1'b1;
            else                          grant_d = 1'b1;
`endif
         end else if (i_read) begin
            grant_i = 1'b1;
         end else if (d_req) begin
            grant_d = 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------
   // FSM: state register and next-state logic
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (grant_d)      state_d = SERVE_D;
            else if (grant_i) state_d = SERVE_I;
         end
         SERVE_I: if (mem_resp) state_d = IDLE;
         SERVE_D: if (mem_resp) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // A mem_resp that arrives while IDLE is ignored.
   assign resp_now = (state_q != IDLE) && mem_resp;

   // ------------------------------------------------------------------
   // Memory-side registers. They load only on a grant, so they stay stable
   // for the whole SERVE state whatever the requesters do.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_addr  <= '0;
         mem_read  <= 1'b0;
         mem_write <= 1'b0;
         mem_wdata <= '0;
      end else if (grant_i) begin
         mem_addr  <= {i_addr[ADDR_W-1:5], 5'b0};
         mem_read  <= 1'b1;
         mem_write <= 1'b0;
      end else if (grant_d) begin
         mem_addr <= {d_addr[ADDR_W-1:5], 5'b0};
         if (d_write) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b1;
            mem_wdata <= d_wdata;
         end else begin
            mem_read  <= 1'b1;
            mem_write <= 1'b0;
         end
      end else if (resp_now) begin
         mem_read  <= 1'b0;
         mem_write <= 1'b0;
      end
   end

   // ------------------------------------------------------------------
   // Fairness state
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_cnt <= '0;
      end else begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
         starve_cnt <= '0;
`else
         if (grant_i)
            starve_cnt <= '0;
         else if (conflict && grant_d && (starve_cnt != STARVE_LIM))
            starve_cnt <= starve_cnt + 1'b1;
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)          last_winner <= WIN_I;
      else if (grant_i) last_winner <= WIN_I;
      else if (grant_d) last_winner <= WIN_D;
   end

   // ------------------------------------------------------------------
   // Requester-side outputs: rdata is passed straight through in the resp
   // cycle and forced to zero otherwise.
   // ------------------------------------------------------------------
   assign i_resp  = (state_q == SERVE_I) && mem_resp;
   assign d_resp  = (state_q == SERVE_D) && mem_resp;
   assign i_rdata = i_resp ? mem_rdata : '0;
   assign d_rdata = d_resp ? mem_rdata : '0;

   assign busy            = (state_q != IDLE);
   assign dbg_state       = state_q;
   assign dbg_starve_cnt  = starve_cnt;
   assign dbg_last_winner = last_winner;

endmodule

// File: tb/tb_mem_line_arbiter.sv
// tb_mem_line_arbiter
//
// Directed bench for mem_line_arbiter. A cycle table covers single-side
// reads and writes, rdata gating, request hold and back-to-back turnaround.
// Hand-written sequences cover conflict fairness, reset during a transaction
// and a long adapter delay.
// Inputs are driven on the falling edge. Outputs are sampled 1 time unit later.

module tb_mem_line_arbiter;

   localparam int ADDR_W     = 32;
   localparam int LINE_W     = 256;
   localparam int STARVE_MAX = 8;
   localparam int CNT_W      = 4;

   localparam logic L = 1'b0;
   localparam logic H = 1'b1;
   localparam logic [LINE_W-1:0] Z  = '0;
   localparam logic [LINE_W-1:0] PA = {32{8'hA5}};
   localparam logic [LINE_W-1:0] PB = {32{8'h3C}};
   localparam logic [LINE_W-1:0] R1 = {8{32'hDEAD_0001}};
   localparam logic [LINE_W-1:0] R2 = {8{32'hBEEF_0002}};
   localparam logic [LINE_W-1:0] R3 = {8{32'h1234_5678}};

   // ---------------- clock / reset / DUT ----------------
   logic              clk = 1'b0;
   logic              rst;
   logic [ADDR_W-1:0] i_addr, d_addr, mem_addr;
   logic              i_read, i_resp, d_read, d_write, d_resp;
   logic [LINE_W-1:0] i_rdata, d_rdata, d_wdata, mem_wdata, mem_rdata;
   logic              mem_read, mem_write, mem_resp, busy;
   logic [1:0]        dbg_state;
   logic [CNT_W-1:0]  dbg_starve_cnt;
   logic              dbg_last_winner;

   always #5 clk = ~clk;

   mem_line_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .STARVE_MAX(STARVE_MAX)) dut (
      .clk(clk), .rst(rst),
      .i_addr(i_addr), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp),
      .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_resp(d_resp),
      .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
      .busy(busy), .dbg_state(dbg_state), .dbg_starve_cnt(dbg_starve_cnt),
      .dbg_last_winner(dbg_last_winner)
   );

   // Protocol assertions on the bench side of the interface.
   always @(posedge clk) begin
      if (!rst) begin
         assert (!(d_read && d_write)) else $error("illegal d_read and d_write together");
         assert (!(mem_resp && !busy)) else $error("mem_resp while arbiter idle");
      end
   end

   // ---------------- scoreboard counters and checker ----------------
   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [LINE_W-1:0] act,
                        input logic [LINE_W-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_busy(input string name);
      int waited = 0;
      while (busy !== 1'b1 && waited < 20) begin
         @(negedge clk); #1;
         waited++;
      end
      n_vec++;
      if (busy !== 1'b1) begin
         n_err++;
         $display("FAIL %s: busy not seen within 20 cycles", name);
      end
   endtask

   task automatic idle_inputs();
      i_read = 0; i_addr = '0; d_read = 0; d_write = 0; d_addr = '0;
      d_wdata = '0; mem_resp = 0; mem_rdata = '0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      idle_inputs();
      rst = 1;
      repeat (2) @(negedge clk);
      rst = 0;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic              i_read;
      logic [ADDR_W-1:0] i_addr;
      logic              d_read;
      logic              d_write;
      logic [ADDR_W-1:0] d_addr;
      logic [LINE_W-1:0] d_wdata;
      logic              mem_resp;
      logic [LINE_W-1:0] mem_rdata;
      logic              e_busy;
      logic              e_mem_read;
      logic              e_mem_write;
      logic [ADDR_W-1:0] e_mem_addr;
      logic [LINE_W-1:0] e_mem_wdata;
      logic              e_i_resp;
      logic [LINE_W-1:0] e_i_rdata;
      logic              e_d_resp;
      logic [LINE_W-1:0] e_d_rdata;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(
      input logic ir, input logic [ADDR_W-1:0] ia, input logic dr, input logic dw,
      input logic [ADDR_W-1:0] da, input logic [LINE_W-1:0] dwd,
      input logic mr, input logic [LINE_W-1:0] mrd,
      input logic eb, input logic emr, input logic emw, input logic [ADDR_W-1:0] ema,
      input logic [LINE_W-1:0] emwd, input logic eir, input logic [LINE_W-1:0] eird,
      input logic edr, input logic [LINE_W-1:0] edrd);
      vec_t v;
      v.i_read = ir; v.i_addr = ia; v.d_read = dr; v.d_write = dw; v.d_addr = da;
      v.d_wdata = dwd; v.mem_resp = mr; v.mem_rdata = mrd;
      v.e_busy = eb; v.e_mem_read = emr; v.e_mem_write = emw; v.e_mem_addr = ema;
      v.e_mem_wdata = emwd; v.e_i_resp = eir; v.e_i_rdata = eird;
      v.e_d_resp = edr; v.e_d_rdata = edrd;
      return v;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1;
      idle_inputs();

      // Each row: inputs for one cycle, then the outputs expected in that cycle.
      //             ir ia            dr dw da            dwd mr mrd | eb emr emw ema          emwd eir eird edr edrd
      // I-only read, response 5 cycles after the request.
      tbl.push_back(mk(L, 32'h0,        L, L, 32'h0,        Z,  L, Z,   L, L, L, 32'h0,        Z,  L, Z,  L, Z));
      tbl.push_back(mk(H, 32'h1234,     L, L, 32'h0,        Z,  L, Z,   L, L, L, 32'h0,        Z,  L, Z,  L, Z));
      tbl.push_back(mk(H, 32'h1234,     L, L, 32'h0,        Z,  L, Z,   H, H, L, 32'h1220,     Z,  L, Z,  L, Z));
      tbl.push_back(mk(H, 32'h1234,     L, L, 32'h0,        Z,  L, R2,  H, H, L, 32'h1220,     Z,  L, Z,  L, Z));
      tbl.push_back(mk(H, 32'h1234,     L, L, 32'h0,        Z,  L, Z,   H, H, L, 32'h1220,     Z,  L, Z,  L, Z));
      tbl.push_back(mk(H, 32'h1234,     L, L, 32'h0,        Z,  L, Z,   H, H, L, 32'h1220,     Z,  L, Z,  L, Z));
      tbl.push_back(mk(H, 32'h1234,     L, L, 32'h0,        Z,  H, R1,  H, H, L, 32'h1220,     Z,  H, R1, L, Z));
      tbl.push_back(mk(L, 32'h0,        L, L, 32'h0,        Z,  L, R1,  L, L, L, 32'h1220,     Z,  L, Z,  L, Z));
      // D writeback.
      tbl.push_back(mk(L, 32'h0,        L, H, 32'h8000_0040, PA, L, Z,  L, L, L, 32'h1220,     Z,  L, Z,  L, Z));
      tbl.push_back(mk(L, 32'h0,        L, H, 32'h8000_0040, PA, L, Z,  H, L, H, 32'h8000_0040, PA, L, Z,  L, Z));
      tbl.push_back(mk(L, 32'h0,        L, H, 32'h8000_0040, PA, H, R2, H, L, H, 32'h8000_0040, PA, L, Z,  H, R2));
      tbl.push_back(mk(L, 32'h0,        L, L, 32'h0,        Z,  L, Z,   L, L, L, 32'h8000_0040, PA, L, Z,  L, Z));
      // D read with an unaligned address; the address changes mid-serve and is ignored.
      tbl.push_back(mk(L, 32'h0,        H, L, 32'h0000_00FF, Z, L, Z,   L, L, L, 32'h8000_0040, PA, L, Z,  L, Z));
      tbl.push_back(mk(L, 32'h0,        H, L, 32'h0000_0777, Z, L, Z,   H, H, L, 32'h0000_00E0, PA, L, Z,  L, Z));
      // Back-to-back: request still high after resp becomes a new request.
      tbl.push_back(mk(L, 32'h0,        H, L, 32'h0000_0100, Z, H, R3,  H, H, L, 32'h0000_00E0, PA, L, Z,  H, R3));
      tbl.push_back(mk(L, 32'h0,        H, L, 32'h0000_0100, Z, L, Z,   L, L, L, 32'h0000_00E0, PA, L, Z,  L, Z));
      tbl.push_back(mk(L, 32'h0,        H, L, 32'h0000_0100, Z, L, Z,   H, H, L, 32'h0000_0100, PA, L, Z,  L, Z));
      tbl.push_back(mk(L, 32'h0,        H, L, 32'h0000_0100, Z, H, R1,  H, H, L, 32'h0000_0100, PA, L, Z,  H, R1));
      tbl.push_back(mk(L, 32'h0,        L, L, 32'h0,        Z,  L, Z,   L, L, L, 32'h0000_0100, PA, L, Z,  L, Z));

      // ---- reset state ----
      repeat (3) @(negedge clk);
      rst = 0;
      #1;
      check("rst busy",        256'(busy),            256'(1'b0));
      check("rst mem_read",    256'(mem_read),        256'(1'b0));
      check("rst mem_write",   256'(mem_write),       256'(1'b0));
      check("rst mem_addr",    256'(mem_addr),        256'(32'h0));
      check("rst mem_wdata",   mem_wdata,             Z);
      check("rst state",       256'(dbg_state),       256'(2'd0));
      check("rst starve_cnt",  256'(dbg_starve_cnt),  256'(4'd0));
      check("rst last_winner", 256'(dbg_last_winner), 256'(1'b0));
      check("rst i_resp",      256'(i_resp),          256'(1'b0));
      check("rst d_resp",      256'(d_resp),          256'(1'b0));

      // ---- table ----
      for (int i = 0; i < tbl.size(); i++) begin
         vec_t t;
         t = tbl[i];
         @(negedge clk);
         i_read = t.i_read; i_addr = t.i_addr; d_read = t.d_read; d_write = t.d_write;
         d_addr = t.d_addr; d_wdata = t.d_wdata; mem_resp = t.mem_resp; mem_rdata = t.mem_rdata;
         #1;
         check($sformatf("v%0d busy", i),      256'(busy),      256'(t.e_busy));
         check($sformatf("v%0d mem_read", i),  256'(mem_read),  256'(t.e_mem_read));
         check($sformatf("v%0d mem_write", i), 256'(mem_write), 256'(t.e_mem_write));
         check($sformatf("v%0d mem_addr", i),  256'(mem_addr),  256'(t.e_mem_addr));
         check($sformatf("v%0d mem_wdata", i), mem_wdata,       t.e_mem_wdata);
         check($sformatf("v%0d i_resp", i),    256'(i_resp),    256'(t.e_i_resp));
         check($sformatf("v%0d i_rdata", i),   i_rdata,         t.e_i_rdata);
         check($sformatf("v%0d d_resp", i),    256'(d_resp),    256'(t.e_d_resp));
         check($sformatf("v%0d d_rdata", i),   d_rdata,         t.e_d_rdata);
      end

      // ---- conflict fairness: both sides held continuously ----
      do_reset();
      i_read = 1; i_addr = 32'h1000; d_read = 1; d_addr = 32'h2000;
      #1;
      for (int k = 0; k < 10; k++) begin
         logic             exp_i;
         logic [CNT_W-1:0] exp_cnt;
`ifdef MEM_ARB_ROUND_ROBIN_EN
         exp_i   = (k % 2) == 1;
         exp_cnt = 4'd0;
`else
         exp_i   = (k == 8);
         exp_cnt = (k < 8) ? 4'(k + 1) : (k == 8 ? 4'd0 : 4'd1);
`endif
         wait_busy($sformatf("conf%0d grant", k));
         check($sformatf("conf%0d mem_addr", k),   256'(mem_addr), 256'(exp_i ? 32'h1000 : 32'h2000));
         check($sformatf("conf%0d starve_cnt", k), 256'(dbg_starve_cnt), 256'(exp_cnt));
         mem_resp = 1; mem_rdata = R1;
         #1;
         check($sformatf("conf%0d i_resp", k), 256'(i_resp), 256'(exp_i));
         check($sformatf("conf%0d d_resp", k), 256'(d_resp), 256'(!exp_i));
         @(negedge clk);
         mem_resp = 0; mem_rdata = '0;
         #1;
      end
      @(negedge clk);
      i_read = 0; d_read = 0;
      @(negedge clk);

      // ---- reset in the middle of a D transaction ----
      do_reset();
      d_read = 1; d_addr = 32'h3000;
      @(negedge clk); #1;
      check("rstmid strobe up", 256'(mem_read), 256'(1'b1));
      @(negedge clk); #1;
      rst = 1;
      #1;
      check("rstmid mem_read",  256'(mem_read),  256'(1'b0));
      check("rstmid mem_write", 256'(mem_write), 256'(1'b0));
      check("rstmid busy",      256'(busy),      256'(1'b0));
      check("rstmid d_resp",    256'(d_resp),    256'(1'b0));
      check("rstmid state",     256'(dbg_state), 256'(2'd0));
      @(negedge clk);
      d_read = 0; d_addr = '0; rst = 0;
      @(negedge clk);
      i_read = 1; i_addr = 32'h4000;
      #1;
      wait_busy("rstmid i grant");
      check("rstmid i mem_read", 256'(mem_read), 256'(1'b1));
      check("rstmid i mem_addr", 256'(mem_addr), 256'(32'h4000));
      mem_resp = 1; mem_rdata = R2;
      #1;
      check("rstmid i_resp",  256'(i_resp), 256'(1'b1));
      check("rstmid i_rdata", i_rdata,      R2);
      check("rstmid no d_resp", 256'(d_resp), 256'(1'b0));
      @(negedge clk);
      i_read = 0; mem_resp = 0; mem_rdata = '0;

      // ---- long adapter delay with requester inputs toggling ----
      @(negedge clk);
      d_write = 1; d_addr = 32'h5000_003F; d_wdata = PB;
      #1;
      wait_busy("late grant");
      check("late mem_write", 256'(mem_write), 256'(1'b1));
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         d_addr  = $urandom;
         i_addr  = $urandom;
         d_wdata = {8{$urandom}};
         i_read  = 1'($urandom_range(0, 1));
         #1;
         check($sformatf("late%0d mem_addr", c),  256'(mem_addr),  256'(32'h5000_0020));
         check($sformatf("late%0d mem_wdata", c), mem_wdata,       PB);
         check($sformatf("late%0d mem_write", c), 256'(mem_write), 256'(1'b1));
         check($sformatf("late%0d d_resp", c),    256'(d_resp),    256'(1'b0));
      end
      @(negedge clk);
      i_read = 0; mem_resp = 1; mem_rdata = R3;
      #1;
      check("late d_resp",  256'(d_resp), 256'(1'b1));
      check("late d_rdata", d_rdata,      R3);
      check("late i_resp",  256'(i_resp), 256'(1'b0));
      check("late i_rdata", i_rdata,      Z);
      @(negedge clk);
      d_write = 0; mem_resp = 0; mem_rdata = '0;
      #1;
      check("late idle busy",      256'(busy),      256'(1'b0));
      check("late idle mem_write", 256'(mem_write), 256'(1'b0));

      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
